// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the RISC_toy pipeline and hazard_unit_mc.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_unit_mc_if #(
    parameter int AW = 5,
    parameter int PW = 16
);
    logic [AW-1:0] RA0_D, RA1_D, RA0_E, RA1_E;
    logic          RS1Used_D, RS2Used_D, RS1Used_E, RS2Used_E;
    logic [AW-1:0] WA_E, WA_M, WA_W;
    logic          WEN_E, WEN_M, WEN_W;
    logic          Load_E, Taken_E, MDUStart_E;
    logic          PCWrite, IMRead, FDWrite, DEWrite;
    logic          FDFlush, DEFlush, EMFlush;
    logic [1:0]    FW1, FW2;
    logic          MDUBusy;
    logic [PW-1:0] StallCnt, FlushCnt;

    modport master (
        output RA0_D, RA1_D, RA0_E, RA1_E,
        output RS1Used_D, RS2Used_D, RS1Used_E, RS2Used_E,
        output WA_E, WA_M, WA_W, WEN_E, WEN_M, WEN_W,
        output Load_E, Taken_E, MDUStart_E,
        input  PCWrite, IMRead, FDWrite, DEWrite, FDFlush, DEFlush, EMFlush,
        input  FW1, FW2, MDUBusy, StallCnt, FlushCnt
    );

    modport slave (
        input  RA0_D, RA1_D, RA0_E, RA1_E,
        input  RS1Used_D, RS2Used_D, RS1Used_E, RS2Used_E,
        input  WA_E, WA_M, WA_W, WEN_E, WEN_M, WEN_W,
        input  Load_E, Taken_E, MDUStart_E,
        output PCWrite, IMRead, FDWrite, DEWrite, FDFlush, DEFlush, EMFlush,
        output FW1, FW2, MDUBusy, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage RISC_toy pipeline: load-use and
// W->D stalls, M/W bypass select, taken-branch flush, MDU hold FSM, perf counters.
module hazard_unit_mc #(
    parameter int AW        = 5,
    parameter int MUL_LAT   = 4,
    parameter int CW        = 4,
    parameter int RF_BYPASS = 0,
    parameter int ZERO_REG  = 1,
    parameter int PW        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    hazard_unit_mc_if.slave  hz
);
    typedef enum logic {IDLE, BUSY} state_e;

    localparam int            INIT_I   = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam logic [CW-1:0] CNT_INIT = CW'(INIT_I);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] stall_cnt_q, flush_cnt_q;
    logic          hold, stall_evt, flush_evt;

    // WEN_* are active-low: a match requires the producer to actually write.
    function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] w,
                                   input logic wen_n, input logic used);
        return used && !wen_n && (a == w) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [AW-1:0] ra_d [2];
    logic [AW-1:0] ra_e [2];
    logic [1:0]    used_d, used_e, ld_hit, wb_hit;
    logic [1:0]    fw [2];
    logic          ldstall, wbstall;

    assign ra_d[0] = hz.RA0_D;
    assign ra_d[1] = hz.RA1_D;
    assign ra_e[0] = hz.RA0_E;
    assign ra_e[1] = hz.RA1_E;
    assign used_d  = {hz.RS2Used_D, hz.RS1Used_D};
    assign used_e  = {hz.RS2Used_E, hz.RS1Used_E};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ld_hit[gi] = match(ra_d[gi], hz.WA_E, hz.WEN_E, used_d[gi]);
            assign wb_hit[gi] = match(ra_d[gi], hz.WA_W, hz.WEN_W, used_d[gi]);
            // M is younger than W, so it wins when both hold the register.
            assign fw[gi] = match(ra_e[gi], hz.WA_M, hz.WEN_M, used_e[gi]) ? 2'd1 :
                            match(ra_e[gi], hz.WA_W, hz.WEN_W, used_e[gi]) ? 2'd2 : 2'd0;
        end
    endgenerate

    assign ldstall = hz.Load_E && !hz.WEN_E && (|ld_hit);
    assign wbstall = (RF_BYPASS == 0) && (|wb_hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.MDUStart_E && (MUL_LAT > 1)) begin
                    hold    = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hz.PCWrite = 1'b1;
        hz.IMRead  = 1'b1;
        hz.FDWrite = 1'b1;
        hz.DEWrite = 1'b1;
        hz.FDFlush = 1'b0;
        hz.DEFlush = 1'b0;
        hz.EMFlush = 1'b0;
        hz.FW1     = fw[0];
        hz.FW2     = fw[1];
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        if (RST) begin
            hz.PCWrite = 1'b0;
            hz.IMRead  = 1'b0;
            hz.FDWrite = 1'b0;
            hz.DEWrite = 1'b0;
            hz.FDFlush = 1'b1;
            hz.DEFlush = 1'b1;
            hz.EMFlush = 1'b1;
            hz.FW1     = 2'd0;
            hz.FW2     = 2'd0;
        end else if (hold) begin
            hz.PCWrite = 1'b0;
            hz.IMRead  = 1'b0;
            hz.FDWrite = 1'b0;
            hz.DEWrite = 1'b0;
            hz.EMFlush = 1'b1;
            stall_evt  = 1'b1;
        end else if (hz.Taken_E) begin
            // The D instruction is squashed, so any stall it would cause is moot.
            hz.FDFlush = 1'b1;
            hz.DEFlush = 1'b1;
            flush_evt  = 1'b1;
        end else if (ldstall || wbstall) begin
            hz.PCWrite = 1'b0;
            hz.IMRead  = 1'b0;
            hz.FDWrite = 1'b0;
            hz.DEFlush = 1'b1;
            stall_evt  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PW'(1);
            if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + PW'(1);
        end
    end

    assign hz.MDUBusy  = (state_q == BUSY);
    assign hz.StallCnt = stall_cnt_q;
    assign hz.FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: a default-configured instance plus an alternate one
// (MUL_LAT=1, write-through RF, no zero register, 3-bit counters), both checked per cycle.
module tb_hazard_unit_mc;
    localparam int ML_M = 4, ML_A = 1;
    localparam bit RFB_M = 0, RFB_A = 1;
    localparam bit ZR_M = 1, ZR_A = 0;
    localparam int SAT_M = 65535, SAT_A = 7;
    localparam int A_RST = 0, A_HOLD = 1, A_FLUSH = 2, A_STALL = 3, A_RUN = 4;

    typedef struct packed {
        logic [4:0] ra0_d, ra1_d, ra0_e, ra1_e, wa_e, wa_m, wa_w;
        logic u1d, u2d, u1e, u2e, wen_e, wen_m, wen_w, load_e, taken_e, mdu;
    } stim_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  chk_on = 1'b0;
    stim_t st, s;
    int    tests = 0, fails = 0;
    int    k_m = 0, k_a = 0, sc_m = 0, fc_m = 0, sc_a = 0, fc_a = 0;

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.AW(5), .PW(16)) if_m();
    hazard_unit_mc_if #(.AW(5), .PW(3))  if_a();

    hazard_unit_mc u_main (.CLK(clk), .RST(rst), .hz(if_m));
    hazard_unit_mc #(.AW(5), .MUL_LAT(ML_A), .CW(4), .RF_BYPASS(1), .ZERO_REG(0), .PW(3))
        u_alt (.CLK(clk), .RST(rst), .hz(if_a));

    logic [11:0] ctl_m, ctl_a;
    assign ctl_m = {if_m.PCWrite, if_m.IMRead, if_m.FDWrite, if_m.DEWrite, if_m.FDFlush,
                    if_m.DEFlush, if_m.EMFlush, if_m.FW1, if_m.FW2, if_m.MDUBusy};
    assign ctl_a = {if_a.PCWrite, if_a.IMRead, if_a.FDWrite, if_a.DEWrite, if_a.FDFlush,
                    if_a.DEFlush, if_a.EMFlush, if_a.FW1, if_a.FW2, if_a.MDUBusy};

    // ---------------- reference model ----------------
    function automatic bit hits(input logic [4:0] a, input logic [4:0] w, input logic wen_n,
                                input logic used, input bit zr);
        return used && !wen_n && (a == w) && !(zr && a == 0);
    endfunction

    function automatic int src(input stim_t x, input logic [4:0] a, input logic used, input bit zr);
        if (hits(a, x.wa_m, x.wen_m, used, zr)) return 1;
        if (hits(a, x.wa_w, x.wen_w, used, zr)) return 2;
        return 0;
    endfunction

    // k = number of hold cycles already spent on the current MDU op.
    function automatic int act_of(input stim_t x, input logic r, input int k, input int ml,
                                  input bit rfb, input bit zr);
        bit holding, ld, wb;
        if (r) return A_RST;
        holding = (k > 0) ? (k < ml - 1) : (x.mdu && ml > 1);
        if (holding) return A_HOLD;
        if (x.taken_e) return A_FLUSH;
        ld = x.load_e && !x.wen_e && (hits(x.ra0_d, x.wa_e, x.wen_e, x.u1d, zr) ||
                                      hits(x.ra1_d, x.wa_e, x.wen_e, x.u2d, zr));
        wb = !rfb && (hits(x.ra0_d, x.wa_w, x.wen_w, x.u1d, zr) ||
                      hits(x.ra1_d, x.wa_w, x.wen_w, x.u2d, zr));
        return (ld || wb) ? A_STALL : A_RUN;
    endfunction

    function automatic logic [11:0] model_ctl(input stim_t x, input logic r, input int k,
                                              input int ml, input bit rfb, input bit zr);
        logic [6:0] en;
        logic [1:0] f1, f2;
        case (act_of(x, r, k, ml, rfb, zr))
            A_RST:   en = 7'b0000_111;
            A_HOLD:  en = 7'b0000_001;
            A_FLUSH: en = 7'b1111_110;
            A_STALL: en = 7'b0001_010;
            default: en = 7'b1111_000;
        endcase
        f1 = r ? 2'd0 : 2'(src(x, x.ra0_e, x.u1e, zr));
        f2 = r ? 2'd0 : 2'(src(x, x.ra1_e, x.u2e, zr));
        return {en, f1, f2, (k > 0)};
    endfunction

    always @(posedge clk) begin
        int am, aa;
        am = act_of(st, rst, k_m, ML_M, RFB_M, ZR_M);
        aa = act_of(st, rst, k_a, ML_A, RFB_A, ZR_A);
        if (rst) begin
            k_m <= 0; k_a <= 0; sc_m <= 0; fc_m <= 0; sc_a <= 0; fc_a <= 0;
        end else begin
            k_m  <= (am == A_HOLD) ? k_m + 1 : 0;
            k_a  <= (aa == A_HOLD) ? k_a + 1 : 0;
            sc_m <= ((am == A_HOLD || am == A_STALL) && sc_m < SAT_M) ? sc_m + 1 : sc_m;
            fc_m <= (am == A_FLUSH && fc_m < SAT_M) ? fc_m + 1 : fc_m;
            sc_a <= ((aa == A_HOLD || aa == A_STALL) && sc_a < SAT_A) ? sc_a + 1 : sc_a;
            fc_a <= (aa == A_FLUSH && fc_a < SAT_A) ? fc_a + 1 : fc_a;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [11:0] e;
        if (chk_on) begin
            e = model_ctl(st, rst, k_m, ML_M, RFB_M, ZR_M);
            tests++;
            if (ctl_m !== e) begin
                fails++;
                $display("FAIL main_ctl t=%0t got=%b want=%b", $time, ctl_m, e);
            end
            tests++;
            if (if_m.StallCnt !== sc_m[15:0] || if_m.FlushCnt !== fc_m[15:0]) begin
                fails++;
                $display("FAIL main_cnt t=%0t got=%0d/%0d want=%0d/%0d", $time,
                         if_m.StallCnt, if_m.FlushCnt, sc_m, fc_m);
            end
            e = model_ctl(st, rst, k_a, ML_A, RFB_A, ZR_A);
            tests++;
            if (ctl_a !== e) begin
                fails++;
                $display("FAIL alt_ctl t=%0t got=%b want=%b", $time, ctl_a, e);
            end
            tests++;
            if (if_a.StallCnt !== sc_a[2:0] || if_a.FlushCnt !== fc_a[2:0]) begin
                fails++;
                $display("FAIL alt_cnt t=%0t got=%0d/%0d want=%0d/%0d", $time,
                         if_a.StallCnt, if_a.FlushCnt, sc_a, fc_a);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle_s();
        stim_t x;
        x = '0;
        x.wen_e = 1'b1;
        x.wen_m = 1'b1;
        x.wen_w = 1'b1;
        return x;
    endfunction

    task automatic put(input stim_t x);
        st = x;
        if_m.RA0_D = x.ra0_d;       if_a.RA0_D = x.ra0_d;
        if_m.RA1_D = x.ra1_d;       if_a.RA1_D = x.ra1_d;
        if_m.RA0_E = x.ra0_e;       if_a.RA0_E = x.ra0_e;
        if_m.RA1_E = x.ra1_e;       if_a.RA1_E = x.ra1_e;
        if_m.RS1Used_D = x.u1d;     if_a.RS1Used_D = x.u1d;
        if_m.RS2Used_D = x.u2d;     if_a.RS2Used_D = x.u2d;
        if_m.RS1Used_E = x.u1e;     if_a.RS1Used_E = x.u1e;
        if_m.RS2Used_E = x.u2e;     if_a.RS2Used_E = x.u2e;
        if_m.WA_E = x.wa_e;         if_a.WA_E = x.wa_e;
        if_m.WA_M = x.wa_m;         if_a.WA_M = x.wa_m;
        if_m.WA_W = x.wa_w;         if_a.WA_W = x.wa_w;
        if_m.WEN_E = x.wen_e;       if_a.WEN_E = x.wen_e;
        if_m.WEN_M = x.wen_m;       if_a.WEN_M = x.wen_m;
        if_m.WEN_W = x.wen_w;       if_a.WEN_W = x.wen_w;
        if_m.Load_E = x.load_e;     if_a.Load_E = x.load_e;
        if_m.Taken_E = x.taken_e;   if_a.Taken_E = x.taken_e;
        if_m.MDUStart_E = x.mdu;    if_a.MDUStart_E = x.mdu;
    endtask

    task automatic step(input string nm, input stim_t x, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        put(x);
        #2;
        $display("[TB] cycle t=%0t %s rst=%0b", $time, nm, r);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic stim_t ld_s(input logic taken);
        stim_t x;
        x = idle_s();
        x.load_e = 1'b1; x.wen_e = 1'b0; x.wa_e = 5'd5;
        x.ra0_d = 5'd5;  x.u1d = 1'b1;   x.taken_e = taken;
        return x;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        put(idle_s());
        @(posedge clk);
        #1 chk_on = 1'b1;

        step("reset", idle_s(), 1'b1);
        chk("rst_pcwrite", int'(if_m.PCWrite), 0);
        chk("rst_flushes", int'({if_m.FDFlush, if_m.DEFlush, if_m.EMFlush}), 7);
        chk("rst_busy", int'(if_m.MDUBusy), 0);
        step("idle", idle_s(), 1'b0);
        chk("idle_pcwrite", int'(if_m.PCWrite), 1);
        chk("idle_stallcnt", int'(if_m.StallCnt), 0);

        step("load-use", ld_s(1'b0), 1'b0);
        chk("ld_pcwrite", int'(if_m.PCWrite), 0);
        chk("ld_fdwrite", int'(if_m.FDWrite), 0);
        chk("ld_deflush", int'(if_m.DEFlush), 1);
        chk("ld_stallcnt", int'(if_m.StallCnt), 0);
        s = idle_s(); s.wa_m = 5'd5; s.wen_m = 1'b0; s.ra0_d = 5'd5; s.u1d = 1'b1;
        step("load in M", s, 1'b0);
        chk("ld_stallcnt_after", int'(if_m.StallCnt), 1);
        chk("ld_release", int'(if_m.PCWrite), 1);
        s = idle_s(); s.wa_w = 5'd5; s.wen_w = 1'b0; s.ra0_e = 5'd5; s.u1e = 1'b1;
        step("consumer in E", s, 1'b0);
        chk("ld_fw1_w", int'(if_m.FW1), 2);

        s = idle_s(); s.ra1_e = 5'd7; s.u2e = 1'b1;
        s.wa_m = 5'd7; s.wen_m = 1'b0; s.wa_w = 5'd7; s.wen_w = 1'b0;
        step("fwd M over W", s, 1'b0);
        chk("fw2_m_wins", int'(if_m.FW2), 1);
        s.ra1_e = 5'd0; s.wa_m = 5'd0; s.wa_w = 5'd0;
        step("fwd r0", s, 1'b0);
        chk("fw2_zero_reg", int'(if_m.FW2), 0);
        chk("fw2_r0_alt", int'(if_a.FW2), 1);

        s = idle_s(); s.mdu = 1'b1;
        step("mdu c1", s, 1'b0);
        chk("mdu1_pcwrite", int'(if_m.PCWrite), 0);
        chk("mdu1_emflush", int'(if_m.EMFlush), 1);
        chk("mdu1_alt_nohold", int'(if_a.PCWrite), 1);
        step("mdu c2", s, 1'b0);
        chk("mdu2_busy", int'(if_m.MDUBusy), 1);
        chk("mdu2_dewrite", int'(if_m.DEWrite), 0);
        step("mdu c3", s, 1'b0);
        chk("mdu3_busy", int'(if_m.MDUBusy), 1);
        step("mdu c4 release", s, 1'b0);
        chk("mdu4_pcwrite", int'(if_m.PCWrite), 1);
        chk("mdu4_emflush", int'(if_m.EMFlush), 0);
        step("after mdu", idle_s(), 1'b0);
        chk("mdu_stallcnt", int'(if_m.StallCnt), 4);
        chk("mdu_busy_clr", int'(if_m.MDUBusy), 0);

        step("taken+ldstall", ld_s(1'b1), 1'b0);
        chk("tk_fdflush", int'(if_m.FDFlush), 1);
        chk("tk_deflush", int'(if_m.DEFlush), 1);
        chk("tk_pcwrite", int'(if_m.PCWrite), 1);
        step("after taken", idle_s(), 1'b0);
        chk("tk_flushcnt", int'(if_m.FlushCnt), 1);
        chk("tk_stallcnt", int'(if_m.StallCnt), 4);

        s = idle_s(); s.ra0_d = 5'd3; s.u1d = 1'b1; s.wa_w = 5'd3; s.wen_w = 1'b0;
        step("wb stall", s, 1'b0);
        chk("wb_pcwrite", int'(if_m.PCWrite), 0);
        chk("wb_alt_bypass", int'(if_a.PCWrite), 1);
        step("after wb", idle_s(), 1'b0);
        chk("wb_stallcnt", int'(if_m.StallCnt), 5);
        chk("wb_alt_stallcnt", int'(if_a.StallCnt), 1);

        for (int i = 0; i < 8; i++) step("sat stall", ld_s(1'b0), 1'b0);
        for (int i = 0; i < 8; i++) step("sat flush", ld_s(1'b1), 1'b0);
        step("after sat", idle_s(), 1'b0);
        chk("sat_alt_stall", int'(if_a.StallCnt), 7);
        chk("sat_alt_flush", int'(if_a.FlushCnt), 7);
        chk("sat_main_stall", int'(if_m.StallCnt), 13);
        chk("sat_main_flush", int'(if_m.FlushCnt), 9);

        s = idle_s(); s.mdu = 1'b1;
        step("mdu c1 (pre-reset)", s, 1'b0);
        step("reset mid-hold", s, 1'b1);
        chk("rh_flushes", int'({if_m.FDFlush, if_m.DEFlush, if_m.EMFlush}), 7);
        chk("rh_pcwrite", int'(if_m.PCWrite), 0);
        step("resume", idle_s(), 1'b0);
        chk("rh_busy", int'(if_m.MDUBusy), 0);
        chk("rh_stallcnt", int'(if_m.StallCnt), 0);
        chk("rh_flushcnt", int'(if_m.FlushCnt), 0);
        chk("rh_pcwrite_resume", int'(if_m.PCWrite), 1);
        step("idle", idle_s(), 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Next-generation hazard/forwarding controller for the 5-stage F/D/E/M/W RISC_toy pipeline.
- Adds the following over the existing pass-through unit:
  - load-use stalls and M/W bypass selection;
  - a configurable write-through register-file mode;
  - taken-branch flushes resolved in E;
  - a counter-driven hold FSM for a multi-cycle MDU operating in E;
  - saturating stall and flush performance counters.
- Sits beside the pipeline registers and drives their write-enable and flush controls.

Parameters:
- AW, 5: register address width.
- MUL_LAT, 4: total E-stage residency, in cycles, of an MDU op; legal range 1..2^CW.
- CW, 4: width of the MDU hold counter.
- RF_BYPASS, 0: 1 means the register file is write-through, so no W→D stall is needed; 0 means W→D overlap stalls.
- ZERO_REG, 1: 1 means register 0 never creates a hazard or a forward.
- PW, 16: width of the performance counters.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- RA0_D, RA1_D  in  AW  source addresses in D
- RA0_E, RA1_E  in  AW  source addresses in E
- RS1Used_D, RS2Used_D, RS1Used_E, RS2Used_E  in  1  source-valid qualifiers
- WA_E, WA_M, WA_W  in  AW  destination addresses
- WEN_E, WEN_M, WEN_W  in  1  register write enables, active-low
- Load_E  in  1  instruction in E is a load
- Taken_E  in  1  branch/jump in E is taken
- MDUStart_E  in  1  instruction in E is an MDU op
- PCWrite  out  1  PC update enable
- IMRead  out  1  IM read enable
- FDWrite, DEWrite  out  1  pipeline-register write enables
- FDFlush, DEFlush, EMFlush  out  1  bubble-insert controls
- FW1, FW2  out  2  ALU source select: 0 = regfile, 1 = M, 2 = W
- MDUBusy  out  1  hold FSM is not IDLE
- StallCnt, FlushCnt  out  PW  performance counters

Behaviour:

Match rules:
- match(a, w, wen) = (wen == 0) && (a == w) && !(ZERO_REG && a == 0).
- Every match is also gated by its RSxUsed qualifier.

Forwarding (combinational):
- FW1 = 1 if match(RA0_E, WA_M, WEN_M); else 2 if match(RA0_E, WA_W, WEN_W); else 0.
- FW2 is the same using RA1_E.

Stall sources:
- ldstall = Load_E && !WEN_E && (match(RA0_D, WA_E) || match(RA1_D, WA_E)). This gives exactly one bubble; the consumer later reaches E with the load in W, so FW = 2.
- wbstall = !RF_BYPASS && (match(RA0_D, WA_W, WEN_W) || match(RA1_D, WA_W, WEN_W)).

MDU hold FSM (states IDLE, BUSY; counter cnt of width CW):
- IDLE: if MDUStart_E && MUL_LAT > 1, then hold = 1 this cycle, go to BUSY, cnt <= MUL_LAT-2.
- BUSY: if cnt != 0, then hold = 1 and cnt <= cnt-1.
- BUSY: if cnt == 0, then hold = 0 (E advances) and go to IDLE.
- Total hold cycles = MUL_LAT-1. With MUL_LAT = 1 the FSM never leaves IDLE.
- MDUStart_E stays high while the op is held; it does not retrigger because the op leaves E on the release cycle.
- The MDU latches its operands in the start cycle; FW values during hold are don't-care for it.
- MDUBusy = (state == BUSY).

Output priority, highest first:
1. RST: PCWrite = 0, IMRead = 0, FDWrite = 0, DEWrite = 0, FDFlush = 1, DEFlush = 1, EMFlush = 1, FW = 0. FSM goes to IDLE, cnt = 0, counters clear. Reset mid-hold aborts the hold.
2. hold: PCWrite = 0, IMRead = 0, FDWrite = 0, DEWrite = 0, EMFlush = 1. FDFlush, DEFlush, and the ld/wb stalls are ignored.
3. Taken_E: FDFlush = 1, DEFlush = 1; PCWrite, FDWrite, DEWrite = 1. Taken_E overrides a simultaneous ldstall or wbstall, because the D instruction is squashed.
4. ldstall or wbstall: PCWrite = 0, IMRead = 0, FDWrite = 0, DEFlush = 1, DEWrite = 1.
5. Default: PCWrite, IMRead, FDWrite, DEWrite = 1; all flushes = 0.

Performance counters:
- StallCnt increments on every cycle in which priority 2 or 4 is active.
- FlushCnt increments on every cycle in which priority 3 is active.
- Both saturate at 2^PW-1 and update on the clock edge.

Test Plan:
- Load x5 in E (Load_E = 1, WEN_E = 0, WA_E = 5), RA0_D = 5, RS1Used_D = 1 → one cycle with PCWrite = 0, FDWrite = 0, DEFlush = 1, StallCnt 0 → 1. The consumer later reaches E with WA_W = 5, WEN_W = 0 → FW1 = 2.
- RA1_E = 7 with WA_M = 7, WEN_M = 0 and WA_W = 7, WEN_W = 0 → FW2 = 1 (M wins). Repeat with RA1_E = 0, ZERO_REG = 1 → FW2 = 0.
- MUL_LAT = 4, MDUStart_E held high → hold for 3 cycles (PCWrite = 0, DEWrite = 0, EMFlush = 1, MDUBusy = 1 in cycles 2–3), released in cycle 4, StallCnt = 3. With MUL_LAT = 1 → no hold.
- Taken_E = 1 coincident with ldstall conditions → FDFlush = 1, DEFlush = 1, PCWrite = 1, FlushCnt +1, StallCnt unchanged.
- RF_BYPASS = 0: RA0_D = 3 with WA_W = 3, WEN_W = 0 → one stall cycle. RF_BYPASS = 1 → no stall.
- RST asserted in the 2nd cycle of an MDU hold → all flushes = 1, MDUBusy = 0 on the next cycle, counters = 0. Normal operation resumes the cycle after RST drops.
